// File: rtl/toy_pkg.sv
// Shared types, constants and helpers for the stdout console sink.
// Optional CR LF terminator is selected with STDOUT_UART_CRLF_EN.
package toy_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef STDOUT_UART_CRLF_EN
  localparam int unsigned NCHARS = 6;
`else
  localparam int unsigned NCHARS = 5;
`endif

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic {
    CTL_IDLE,
    CTL_SEND
  } ctl_state_e;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/stdio.sv
// stdio word channel: producer drives val/data, consumer drives rdy.
interface stdio;
  logic        val;
  logic        rdy;
  logic [15:0] data;

  modport in  (input val, input data, output rdy);
  modport out (output val, output data, input rdy);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser (LSB first) with a val/rdy byte input.
// rdy also rises on the last stop-bit clock so frames chain with no idle gap.
module uart_tx_byte
  import toy_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       val_i,
  input  logic [7:0] data_i,
  output logic       rdy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    if (state_q != TX_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + CW'(1);
    end
    case (state_q)
      TX_IDLE: begin
        if (val_i) begin
          state_d = TX_START;
          byte_d  = data_i;
          baud_d  = '0;
        end
      end
      TX_START: begin
        if (baud_last) begin
          state_d = TX_DATA;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          if (val_i) begin
            state_d = TX_START;
            byte_d  = data_i;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rdy_o  = (state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_last);
    done_o = (state_q == TX_STOP) && baud_last;
    case (state_q)
      TX_START: tx_o = 1'b0;
      TX_DATA:  tx_o = byte_q[bit_q];
      default:  tx_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/stdout_uart_tx.sv
// Console sink: prints each accepted 16-bit stdout word as 4 hex chars + LF
// on a UART line. Define STDOUT_UART_CRLF_EN for a CR LF terminator.
module stdout_uart_tx
  import toy_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic clk_i,
  input  logic rst_ni,
  stdio.in     stdout_intf,
  output logic tx_o,
  output logic busy_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [2:0]  LAST_IDX     = 3'(NCHARS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("stdout_uart_tx: CLK_HZ/BAUD must be at least 2");
  end

  ctl_state_e  ctl_q, ctl_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;
  logic        byte_val, byte_rdy, byte_done;
  logic [7:0]  byte_data;

  function automatic logic [7:0] char_at(input logic [15:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return hex_to_ascii(w[15:12]);
      3'd1:    return hex_to_ascii(w[11:8]);
      3'd2:    return hex_to_ascii(w[7:4]);
      3'd3:    return hex_to_ascii(w[3:0]);
`ifdef STDOUT_UART_CRLF_EN
      3'd4:    return ASCII_CR;
`endif
      default: return ASCII_LF;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctl_q  <= CTL_IDLE;
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      ctl_q  <= ctl_d;
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  // idx_q is the index of the character currently on the line.
  always_comb begin
    ctl_d  = ctl_q;
    word_d = word_q;
    idx_d  = idx_q;
    case (ctl_q)
      CTL_IDLE: begin
        if (stdout_intf.val) begin
          word_d = stdout_intf.data;
          idx_d  = '0;
          ctl_d  = CTL_SEND;
        end
      end
      CTL_SEND: begin
        if (byte_val && byte_rdy) idx_d = idx_q + 3'd1;
        if ((idx_q == LAST_IDX) && byte_done) ctl_d = CTL_IDLE;
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  // In IDLE the first character is taken straight from the channel so the
  // serialiser starts on the accept edge itself, without a pipeline bubble.
  always_comb begin
    stdout_intf.rdy = (ctl_q == CTL_IDLE);
    busy_o          = (ctl_q != CTL_IDLE);
    if (ctl_q == CTL_IDLE) begin
      byte_val  = stdout_intf.val;
      byte_data = char_at(stdout_intf.data, 3'd0);
    end else begin
      byte_val  = (idx_q != LAST_IDX);
      byte_data = char_at(word_q, idx_q + 3'd1);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .val_i (byte_val),
    .data_i(byte_data),
    .rdy_o (byte_rdy),
    .done_o(byte_done),
    .tx_o  (tx_o)
  );

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Self-checking bench for stdout_uart_tx at CLKS_PER_BIT=10; honours
// STDOUT_UART_CRLF_EN when defined for the whole build.
module tb_stdout_uart_tx;

`ifdef STDOUT_UART_CRLF_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 5;
`endif
  localparam int CPB       = 10;
  localparam int FRAME     = 10 * CPB;
  localparam int WORD_CLKS = NCH * FRAME;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy;

  stdio sif();

  stdout_uart_tx #(
    .CLK_HZ(10),
    .BAUD  (1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stdout_intf(sif),
    .tx_o       (tx),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  string hexdig = "0123456789ABCDEF";
  logic [7:0] exp_chars[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference text for a word: printf-style upper-case hex, then terminator.
  task automatic build_model(input logic [15:0] w);
    exp_chars.delete();
    for (int i = 3; i >= 0; i--) begin
      int nib;
      nib = int'((w >> (4 * i)) & 16'hF);
      exp_chars.push_back(hexdig[nib]);
    end
`ifdef STDOUT_UART_CRLF_EN
    exp_chars.push_back(8'h0D);
`endif
    exp_chars.push_back(8'h0A);
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (sif.rdy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rdy", sif.rdy, 1'b1);
  endtask

  task automatic start_word(input logic [15:0] w);
    @(negedge clk);
    wait_rdy();
    sif.val  = 1'b1;
    sif.data = w;
    @(posedge clk);
  endtask

  // Called right after the accept edge; records tx_o once per clock until rdy
  // returns, then checks length, exact waveform and decoded characters.
  task automatic collect(input logic [15:0] w, input logic nv, input logic [15:0] nd,
                         input string tag);
    logic samp[$];
    logic exp_wave[$];
    logic [7:0] got;
    int n, busy_low, diffs, idx;
    n = 0;
    busy_low = 0;
    diffs = 0;
    build_model(w);
    @(negedge clk);
    while (n <= 2000) begin
      if (sif.rdy === 1'b1) break;
      samp.push_back(tx);
      if (busy !== 1'b1) busy_low++;
      if (n == 0) begin
        sif.val  = nv;
        sif.data = nd;
      end
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, WORD_CLKS);
    chk({tag, "_busy"}, busy_low, 0);
    chk({tag, "_idle_tx"}, tx, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    foreach (exp_chars[c]) begin
      for (int k = 0; k < CPB; k++) exp_wave.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int k = 0; k < CPB; k++) exp_wave.push_back(exp_chars[c][b]);
      for (int k = 0; k < CPB; k++) exp_wave.push_back(1'b1);
    end
    foreach (exp_wave[k]) begin
      if (k >= samp.size()) diffs++;
      else if (samp[k] !== exp_wave[k]) diffs++;
    end
    chk({tag, "_wave"}, diffs, 0);
    foreach (exp_chars[c]) begin
      for (int b = 0; b < 8; b++) begin
        idx = c * FRAME + CPB * (b + 1) + CPB / 2;
        got[b] = (idx < samp.size()) ? samp[idx] : 1'bx;
      end
      chk($sformatf("%s_char%0d", tag, c), got, exp_chars[c]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w, w2;
    logic prev;
    int falls, rdy_low;
    sif.val  = 1'b0;
    sif.data = '0;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", sif.rdy, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    falls = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1) falls++;
    end
    chk("post_rst_idle_tx", falls, 0);

    start_word(16'h1A2F);
    collect(16'h1A2F, 1'b0, 16'(($urandom)), "w1a2f");

    start_word(16'hBEEF);
    collect(16'hBEEF, 1'b0, 16'h0000, "beef");

    start_word(16'h1A2F);
    collect(16'h1A2F, 1'b1, 16'h0000, "b2b_a");
    @(posedge clk);
    collect(16'h0000, 1'b0, 16'hFFFF, "b2b_b");

`ifdef STDOUT_UART_CRLF_EN
    start_word(16'h00FF);
    collect(16'h00FF, 1'b0, 16'h1234, "crlf00ff");
`endif

    for (int i = 0; i < 6; i++) begin
      w  = 16'($urandom);
      w2 = 16'($urandom);
      start_word(w);
      if (i % 2 == 1) begin
        collect(w, 1'b1, w2, $sformatf("rnd%0d_a", i));
        @(posedge clk);
        collect(w2, 1'b0, 16'($urandom), $sformatf("rnd%0d_b", i));
      end else begin
        collect(w, 1'b0, w2, $sformatf("rnd%0d", i));
      end
    end

    // Reset while bit 3 of character 2 ('2' = 0x32, bit 3 low) is on the line.
    start_word(16'h1A2F);
    @(negedge clk);
    sif.val = 1'b0;
    repeat (244) @(negedge clk);
    chk("midrst_pre_tx", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rdy", sif.rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    falls = 0;
    rdy_low = 0;
    prev = tx;
    repeat (300) begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) falls++;
      if (sif.rdy !== 1'b1) rdy_low++;
      prev = tx;
    end
    chk("midrst_no_resume", falls, 0);
    chk("midrst_rdy_held", rdy_low, 0);

    w = 16'($urandom);
    start_word(w);
    collect(w, 1'b0, 16'h0000, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
